// File: rtl/pkg_mlpolar.sv
// rtl/pkg_mlpolar.sv - shared types and saturating LLR arithmetic for the MLPolar receive chain
package pkg_mlpolar;

   typedef enum logic [1:0] {
      SC_IDLE,
      SC_LOAD,
      SC_DECODE,
      SC_DONE
   } sc_state_t;

   // Wide enough to hold the sum of two LLRs at the largest supported width (12 bits)
   localparam int LLR_W_MAX = 12;
   typedef logic signed [LLR_W_MAX:0] llr_wide_t;

   function automatic llr_wide_t sat_max(input int w);
      return llr_wide_t'((1 << (w - 1)) - 1);
   endfunction

   function automatic llr_wide_t sat_clip(input llr_wide_t v, input int w);
      llr_wide_t r;
      if (v > sat_max(w)) begin
         r = sat_max(w);
      end else if (v < -sat_max(w)) begin
         r = -sat_max(w);
      end else begin
         r = v;
      end
      return r;
   endfunction

   function automatic llr_wide_t sat_add(input llr_wide_t a, input llr_wide_t b, input int w);
      return sat_clip(a + b, w);
   endfunction

   function automatic llr_wide_t sat_sub(input llr_wide_t a, input llr_wide_t b, input int w);
      return sat_clip(a - b, w);
   endfunction

   function automatic llr_wide_t sat_abs(input llr_wide_t v, input int w);
      llr_wide_t m;
      m = (v < 0) ? -v : v;
      return (m > sat_max(w)) ? sat_max(w) : m;
   endfunction

   function automatic llr_wide_t min_sum(input llr_wide_t a, input llr_wide_t b, input int w);
      llr_wide_t ma;
      llr_wide_t mb;
      llr_wide_t m;
      ma = sat_abs(a, w);
      mb = sat_abs(b, w);
      m  = (ma < mb) ? ma : mb;
      return ((a < 0) != (b < 0)) ? -m : m;
   endfunction

   function automatic int trailing_zeros(input logic [15:0] v);
      int  n;
      logic found;
      n     = 16;
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (!found && v[k]) begin
            n     = k;
            found = 1'b1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/polar_sc_pe.sv
// rtl/polar_sc_pe.sv - combinational SC f/g processing element with saturation
module polar_sc_pe
   import pkg_mlpolar::*;
#(
   parameter int LLR_W = 8
) (
   input  logic                    mode,
   input  logic                    u,
   input  logic signed [LLR_W-1:0] a,
   input  logic signed [LLR_W-1:0] b,
   output logic signed [LLR_W-1:0] y
);

   llr_wide_t aw;
   llr_wide_t bw;
   llr_wide_t r;

   // mode 0: f (left child), mode 1: g (right child) steered by sibling partial sum u
   always_comb begin
      aw = llr_wide_t'(a);
      bw = llr_wide_t'(b);
      if (mode) begin
         r = u ? sat_sub(bw, aw, LLR_W) : sat_add(bw, aw, LLR_W);
      end else begin
         r = min_sum(aw, bw, LLR_W);
      end
      y = r[LLR_W-1:0];
   end

endmodule

// File: rtl/polar_decoder_sc_seq.sv
// rtl/polar_decoder_sc_seq.sv - sequential SC polar decoder with one time-shared f/g element
module polar_decoder_sc_seq
   import pkg_mlpolar::*;
#(
   parameter int LOG2N = 8,
   parameter int LLR_W = 8,
   parameter int CNT_W = LOG2N + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [(1<<LOG2N)-1:0]   frozen_mask,
   input  logic                    start,
   output logic                    busy,
   input  logic                    llr_valid,
   input  logic signed [LLR_W-1:0] llr_in,
   output logic                    llr_ready,
   output logic                    bit_valid,
   output logic                    bit_out,
   output logic [LOG2N-1:0]        bit_idx,
   output logic                    done,
   output logic [CNT_W-1:0]        info_count
);

   localparam int N     = 1 << LOG2N;
   localparam int IDX_W = LOG2N + 1;
   localparam int ST_W  = $clog2(LOG2N);

   sc_state_t state, state_nx;

   logic [N-1:0]       frz;
   logic [LOG2N-1:0]   load_cnt;
   logic [LOG2N-1:0]   leaf;
   logic [LOG2N-1:0]   leaf_nx;
   logic [LOG2N-1:0]   node;
   logic [ST_W-1:0]    stage;
   logic               dec_phase;

   // Stage s occupies entries 2^s .. 2^(s+1)-1; stage LOG2N holds the channel LLRs
   logic signed [LLR_W-1:0] mem [1:2*N-1];
   logic [N-1:0]            beta_l  [LOG2N];
   logic [N-1:0]            beta_nx [LOG2N];

   logic               load_we;
   logic               pe_en;
   logic               dec_en;
   logic               node_last;
   logic [IDX_W-1:0]   stage_size;
   logic [IDX_W-1:0]   a_idx;
   logic [IDX_W-1:0]   b_idx;
   logic [IDX_W-1:0]   w_idx;
   logic [IDX_W-1:0]   ld_idx;
   logic signed [LLR_W-1:0] pe_a;
   logic signed [LLR_W-1:0] pe_b;
   logic signed [LLR_W-1:0] pe_y;
   logic signed [LLR_W-1:0] root_llr;
   logic               pe_mode;
   logic               pe_u;
   logic               u_hat;
   logic               is_info;
   logic [N-1:0]       beta_cur;
   logic [N-1:0]       low_mask;
   logic               climb;

   assign busy      = (state != SC_IDLE);
   assign done      = (state == SC_DONE);
   assign llr_ready = (state == SC_LOAD);

   always_comb begin
      stage_size = IDX_W'(1) << stage;
      w_idx      = stage_size + IDX_W'(node);
      a_idx      = (stage_size << 1) + IDX_W'(node);
      b_idx      = a_idx + stage_size;
      ld_idx     = IDX_W'(N) + IDX_W'(load_cnt);
      node_last  = (IDX_W'(node) == stage_size - 1'b1);
      leaf_nx    = leaf + 1'b1;
   end

   // A leaf whose bit s is set sits in the right subtree at stage s, hence g there
   assign pe_a     = mem[a_idx];
   assign pe_b     = mem[b_idx];
   assign pe_mode  = leaf[stage];
   assign pe_u     = beta_l[stage][node];
   assign root_llr = mem[1];
   assign is_info  = ~frz[leaf];
   assign u_hat    = is_info & root_llr[LLR_W-1];

   polar_sc_pe #(
      .LLR_W (LLR_W)
   ) u_pe (
      .mode (pe_mode),
      .u    (pe_u),
      .a    (pe_a),
      .b    (pe_b),
      .y    (pe_y)
   );

   // Fold the decided bit upward through every right subtree it completes,
   // parking the result at the first stage where it becomes a left sibling
   always_comb begin
      beta_nx     = beta_l;
      beta_cur    = '0;
      beta_cur[0] = u_hat;
      climb       = 1'b1;
      low_mask    = '0;
      for (int s = 0; s < LOG2N; s++) begin
         if (climb) begin
            if (leaf[s]) begin
               low_mask = {N{1'b1}} >> (N - (1 << s));
               beta_cur = ((beta_l[s] ^ beta_cur) & low_mask) | (beta_cur << (1 << s));
            end else begin
               beta_nx[s] = beta_cur;
               climb      = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_nx = state;
      load_we  = 1'b0;
      pe_en    = 1'b0;
      dec_en   = 1'b0;
      unique case (state)
         SC_IDLE: begin
            if (start) state_nx = SC_LOAD;
         end
         SC_LOAD: begin
            if (llr_valid) begin
               load_we = 1'b1;
               if (&load_cnt) state_nx = SC_DECODE;
            end
         end
         SC_DECODE: begin
            if (dec_phase) begin
               dec_en = 1'b1;
               if (&leaf) state_nx = SC_DONE;
            end else begin
               pe_en = 1'b1;
            end
         end
         SC_DONE: begin
            state_nx = SC_IDLE;
         end
         default: begin
            state_nx = SC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SC_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frz        <= '0;
         load_cnt   <= '0;
         leaf       <= '0;
         node       <= '0;
         stage      <= '0;
         dec_phase  <= 1'b0;
         bit_valid  <= 1'b0;
         bit_out    <= 1'b0;
         bit_idx    <= '0;
         info_count <= '0;
      end else begin
         bit_valid <= 1'b0;
         if (state == SC_IDLE && start) begin
            frz        <= frozen_mask;
            info_count <= '0;
            load_cnt   <= '0;
         end
         if (load_we) begin
            load_cnt <= load_cnt + 1'b1;
            if (&load_cnt) begin
               leaf      <= '0;
               node      <= '0;
               stage     <= ST_W'(LOG2N - 1);
               dec_phase <= 1'b0;
            end
         end
         if (pe_en) begin
            if (node_last) begin
               node <= '0;
               if (stage == '0) begin
                  dec_phase <= 1'b1;
               end else begin
                  stage <= stage - 1'b1;
               end
            end else begin
               node <= node + 1'b1;
            end
         end
         if (dec_en) begin
            bit_valid <= is_info;
            bit_out   <= u_hat;
            bit_idx   <= leaf;
            if (is_info) info_count <= info_count + 1'b1;
            leaf      <= leaf_nx;
            stage     <= ST_W'(trailing_zeros(16'(leaf_nx)));
            node      <= '0;
            dec_phase <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load_we) mem[ld_idx] <= llr_in;
      if (pe_en)   mem[w_idx]  <= pe_y;
      if (dec_en)  beta_l      <= beta_nx;
   end

endmodule

// File: doc/polar_decoder_sc_seq.md
Name: polar_decoder_sc_seq

Overview:
- Parametrised successive-cancellation (SC) polar decoder for block length N = 2^LOG2N.
- Replaces the fully combinational per-leaf tree with a single time-shared f/g processing element. It uses a proper per-stage LLR memory and per-stage partial-sum (beta) registers.
- Frozen mask is a runtime input, latched per codeword. Arithmetic is saturating.
- Sits between the per-level LLR demapper and the multilevel bit re-assembler of the MLPolar receive chain.

Parameters:
- LOG2N, 8, log2 of block length N (legal range 2..10).
- LLR_W, 8, signed LLR width in bits (legal range 4..12).
- CNT_W, LOG2N+1, width of info-bit counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- frozen_mask  input  N  bit i = 1 means leaf u_i is frozen; sampled on the cycle start is accepted.
- start  input  1  one-cycle request to begin a codeword; honoured only in IDLE.
- busy  output  1  high from accepted start until the cycle after done.
- llr_valid  input  1  channel LLR present.
- llr_in  input  LLR_W  signed channel LLR, position order 0..N-1.
- llr_ready  output  1  high only in LOAD.
- bit_valid  output  1  one-cycle strobe per decoded info bit.
- bit_out  output  1  decoded info bit, leaf order.
- bit_idx  output  LOG2N  leaf index of bit_out.
- done  output  1  one-cycle pulse after leaf N-1 is decided.
- info_count  output  CNT_W  number of info bits emitted for the last codeword; held until next start.

Behaviour:
- Reset: every output is 0, state is IDLE, all memories are don't-care. Reset mid-LOAD or mid-DECODE aborts immediately, emits no done, and returns to IDLE.
- States:
  - IDLE: start=1 latches frozen_mask, clears info_count, and moves to LOAD. start is ignored in all other states.
  - LOAD: an LLR is written to stage-LOG2N memory at the load address on each cycle where llr_valid && llr_ready. Gaps in llr_valid are allowed. After the N-th beat, move to DECODE on the next cycle.
  - DECODE: one PE operation per cycle, depth-first SC schedule (see below).
  - DONE: one cycle; done=1, busy=1. Then IDLE with busy=0.
- Schedule: for each leaf i = 0..N-1:
  - Recompute only the stages below the highest bit that changed from i-1 to i. For leaf 0, recompute all stages.
  - Within a stage s, one node per cycle (2^s nodes).
  - Use f for left children and g for right children, g conditioned on the beta of the sibling subtree.
  - Then spend one decision cycle.
  - Total DECODE length is exactly N*LOG2N + N cycles (N=8: 32 cycles; N=256: 2304 cycles).
- f(a,b) = sign(a)·sign(b)·min(|a|,|b|). |−2^(LLR_W−1)| saturates to 2^(LLR_W−1)−1.
- g(a,b,u) = b + a if u = 0, else b − a, computed at LLR_W+1 bits and saturated to ±(2^(LLR_W−1)−1).
- Decision cycle:
  - u = 0 if frozen, else u = sign bit of the root LLR. LLR = 0 decides 0.
  - If not frozen: bit_valid=1, bit_out=u, bit_idx=i, info_count++ in the same cycle.
  - Beta is updated combinationally and registered in the same cycle. Left-half betas are XORed into the parent on the completion of each right subtree.
- Outputs are registered; bit_valid asserts in the decision cycle +1 clock.
- All-frozen mask: full schedule runs, no bit_valid, done still pulses, info_count=0.

Decomposition:
- pkg_mlpolar gains:
  - llr_t parametrisation helpers;
  - saturating add/sub and min-sum functions;
  - the sc_state_t enum;
  - the SAT_MAX(LLR_W) constant.
- One sub-module, polar_sc_pe: combinational f/g unit with mode select and saturation, LLR_W parameter.
- LLR memory: one flat register array of 2N−1 entries, indexed by stage offset 2^s + node.

Test Plan:
- LOG2N=3, mask 0x00, all LLR +10 -> bits 0,0,0,0,0,0,0,0; done exactly 32 cycles after the last load beat; info_count=8.
- LOG2N=3, mask 0x00, all LLR −10 -> bits 0,0,0,0,0,0,0,1 (x = all-ones, inverse transform).
- LOG2N=3, mask 0x17, random codeword from the bench encoder, |LLR|=20 correct signs -> 4 bit_valid at bit_idx 3,5,6,7 matching u; info_count=4.
- LOG2N=3, LLR_W=8, all LLR +127, mask 0xFF -> no internal wrap (PE g output probe = 127); no bit_valid; done pulses; info_count=0.
- llr_valid toggled 1-0-1 during LOAD, start pulsed during DECODE -> load count unaffected by gaps; second start ignored; exactly one done.
- rst_n asserted at DECODE cycle 10, then a fresh codeword -> outputs 0 immediately, no done; next codeword decodes correctly with the new mask.
